// File: rtl/cva6_axi_limiter_pkg.sv
// Shared types and constants for the CVA6 AXI outstanding-transaction limiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cva6_axi_limiter_pkg;

    // Width of the outstanding-burst counters and of the RdOutstanding/WrOutstanding ports
    localparam int CNT_W = 8;

    // Quiesce handshake states
    typedef enum logic [1:0] {
        IDLE,
        DRAINING,
        DRAINED
    } drain_state_e;

endpackage

// File: rtl/cva6_axi_txn_limiter_txn_counter.sv
// Outstanding-burst counter: +1 per request handshake, -1 per completion, flags full and underflow.
// Latency: count updates one cycle after inc/dec; at_max and underflow are combinational.
// Backpressure: none itself; at_max is used by the parent to stall new requests.
module txn_counter
    import cva6_axi_limiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             underflow
);

    // A completion with nothing outstanding holds the count at zero and is reported
    assign underflow = dec && (count == '0);
    assign at_max    = (count >= CNT_W'(MAX));

    // Simultaneous inc/dec cancel; decrement never wraps below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cva6_axi_txn_limiter.sv
// Caps outstanding AXI4 read/write bursts, offers a drain (quiesce) handshake and a response watchdog.
// Latency: 0 cycles on every channel; counts and flags update one cycle after the causing handshake.
// Backpressure: AR/AW held off while the count is full, while draining, or in reset; W/R/B ready/valid pass through.
module cva6_axi_txn_limiter
    import cva6_axi_limiter_pkg::*;
#(
    parameter int AXI_ID_WIDTH      = 4,
    parameter int AXI_ADDRESS_WIDTH = 64,
    parameter int AXI_DATA_WIDTH    = 64,
    parameter int AXI_USER_WIDTH    = 1,
    parameter int MAX_RD            = 4,
    parameter int MAX_WR            = 4,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                          Clk,
    input  logic                          Reset,
    // slave side (from the core wrapper)
    input  logic                          s_aw_valid,
    output logic                          s_aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]       s_aw_bits_id,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_aw_bits_addr,
    input  logic [7:0]                    s_aw_bits_len,
    input  logic [2:0]                    s_aw_bits_size,
    input  logic [1:0]                    s_aw_bits_burst,
    input  logic                          s_aw_bits_lock,
    input  logic [3:0]                    s_aw_bits_cache,
    input  logic [2:0]                    s_aw_bits_prot,
    input  logic [3:0]                    s_aw_bits_qos,
    input  logic [3:0]                    s_aw_bits_region,
    input  logic [AXI_USER_WIDTH-1:0]     s_aw_bits_user,
    input  logic                          s_w_valid,
    output logic                          s_w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_w_bits_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_w_bits_strb,
    input  logic                          s_w_bits_last,
    input  logic [AXI_USER_WIDTH-1:0]     s_w_bits_user,
    output logic                          s_b_valid,
    input  logic                          s_b_ready,
    output logic [AXI_ID_WIDTH-1:0]       s_b_bits_id,
    output logic [1:0]                    s_b_bits_resp,
    output logic [AXI_USER_WIDTH-1:0]     s_b_bits_user,
    input  logic                          s_ar_valid,
    output logic                          s_ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]       s_ar_bits_id,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  s_ar_bits_addr,
    input  logic [7:0]                    s_ar_bits_len,
    input  logic [2:0]                    s_ar_bits_size,
    input  logic [1:0]                    s_ar_bits_burst,
    input  logic                          s_ar_bits_lock,
    input  logic [3:0]                    s_ar_bits_cache,
    input  logic [2:0]                    s_ar_bits_prot,
    input  logic [3:0]                    s_ar_bits_qos,
    input  logic [3:0]                    s_ar_bits_region,
    input  logic [AXI_USER_WIDTH-1:0]     s_ar_bits_user,
    output logic                          s_r_valid,
    input  logic                          s_r_ready,
    output logic [AXI_ID_WIDTH-1:0]       s_r_bits_id,
    output logic [AXI_DATA_WIDTH-1:0]     s_r_bits_data,
    output logic [1:0]                    s_r_bits_resp,
    output logic                          s_r_bits_last,
    output logic [AXI_USER_WIDTH-1:0]     s_r_bits_user,
    // master side (toward the interconnect)
    output logic                          m_aw_valid,
    input  logic                          m_aw_ready,
    output logic [AXI_ID_WIDTH-1:0]       m_aw_bits_id,
    output logic [AXI_ADDRESS_WIDTH-1:0]  m_aw_bits_addr,
    output logic [7:0]                    m_aw_bits_len,
    output logic [2:0]                    m_aw_bits_size,
    output logic [1:0]                    m_aw_bits_burst,
    output logic                          m_aw_bits_lock,
    output logic [3:0]                    m_aw_bits_cache,
    output logic [2:0]                    m_aw_bits_prot,
    output logic [3:0]                    m_aw_bits_qos,
    output logic [3:0]                    m_aw_bits_region,
    output logic [AXI_USER_WIDTH-1:0]     m_aw_bits_user,
    output logic                          m_w_valid,
    input  logic                          m_w_ready,
    output logic [AXI_DATA_WIDTH-1:0]     m_w_bits_data,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_w_bits_strb,
    output logic                          m_w_bits_last,
    output logic [AXI_USER_WIDTH-1:0]     m_w_bits_user,
    input  logic                          m_b_valid,
    output logic                          m_b_ready,
    input  logic [AXI_ID_WIDTH-1:0]       m_b_bits_id,
    input  logic [1:0]                    m_b_bits_resp,
    input  logic [AXI_USER_WIDTH-1:0]     m_b_bits_user,
    output logic                          m_ar_valid,
    input  logic                          m_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]       m_ar_bits_id,
    output logic [AXI_ADDRESS_WIDTH-1:0]  m_ar_bits_addr,
    output logic [7:0]                    m_ar_bits_len,
    output logic [2:0]                    m_ar_bits_size,
    output logic [1:0]                    m_ar_bits_burst,
    output logic                          m_ar_bits_lock,
    output logic [3:0]                    m_ar_bits_cache,
    output logic [2:0]                    m_ar_bits_prot,
    output logic [3:0]                    m_ar_bits_qos,
    output logic [3:0]                    m_ar_bits_region,
    output logic [AXI_USER_WIDTH-1:0]     m_ar_bits_user,
    input  logic                          m_r_valid,
    output logic                          m_r_ready,
    input  logic [AXI_ID_WIDTH-1:0]       m_r_bits_id,
    input  logic [AXI_DATA_WIDTH-1:0]     m_r_bits_data,
    input  logic [1:0]                    m_r_bits_resp,
    input  logic                          m_r_bits_last,
    input  logic [AXI_USER_WIDTH-1:0]     m_r_bits_user,
    // control / status
    input  logic                          DrainReq,
    output logic                          DrainAck,
    output logic                          Timeout,
    output logic                          ProtErr,
    output logic [CNT_W-1:0]              RdOutstanding,
    output logic [CNT_W-1:0]              WrOutstanding
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    drain_state_e     state;
    logic             drain_ack_q;
    logic             timeout_q;
    logic             prot_err_q;
    logic [WD_W-1:0]  wd;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic             rd_at_max, wr_at_max, rd_underflow, wr_underflow;
    logic             ar_allow, aw_allow;
    logic             ar_hs, aw_hs, r_hs, r_last_hs, b_hs;

    // Allow terms use registered state only, so no ready->valid loop is created
    assign ar_allow = !Reset && (state == IDLE) && !rd_at_max;
    assign aw_allow = !Reset && (state == IDLE) && !wr_at_max;

    assign m_ar_valid = s_ar_valid && ar_allow;
    assign s_ar_ready = m_ar_ready && ar_allow;
    assign m_aw_valid = s_aw_valid && aw_allow;
    assign s_aw_ready = m_aw_ready && aw_allow;

    // W, R and B handshakes are ungated; W may legally run ahead of a stalled AW
    assign m_w_valid = s_w_valid;
    assign s_w_ready = m_w_ready;
    assign s_r_valid = m_r_valid;
    assign m_r_ready = s_r_ready;
    assign s_b_valid = m_b_valid;
    assign m_b_ready = s_b_ready;

    assign m_aw_bits_id     = s_aw_bits_id;
    assign m_aw_bits_addr   = s_aw_bits_addr;
    assign m_aw_bits_len    = s_aw_bits_len;
    assign m_aw_bits_size   = s_aw_bits_size;
    assign m_aw_bits_burst  = s_aw_bits_burst;
    assign m_aw_bits_lock   = s_aw_bits_lock;
    assign m_aw_bits_cache  = s_aw_bits_cache;
    assign m_aw_bits_prot   = s_aw_bits_prot;
    assign m_aw_bits_qos    = s_aw_bits_qos;
    assign m_aw_bits_region = s_aw_bits_region;
    assign m_aw_bits_user   = s_aw_bits_user;
    assign m_w_bits_data    = s_w_bits_data;
    assign m_w_bits_strb    = s_w_bits_strb;
    assign m_w_bits_last    = s_w_bits_last;
    assign m_w_bits_user    = s_w_bits_user;
    assign s_b_bits_id      = m_b_bits_id;
    assign s_b_bits_resp    = m_b_bits_resp;
    assign s_b_bits_user    = m_b_bits_user;
    assign m_ar_bits_id     = s_ar_bits_id;
    assign m_ar_bits_addr   = s_ar_bits_addr;
    assign m_ar_bits_len    = s_ar_bits_len;
    assign m_ar_bits_size   = s_ar_bits_size;
    assign m_ar_bits_burst  = s_ar_bits_burst;
    assign m_ar_bits_lock   = s_ar_bits_lock;
    assign m_ar_bits_cache  = s_ar_bits_cache;
    assign m_ar_bits_prot   = s_ar_bits_prot;
    assign m_ar_bits_qos    = s_ar_bits_qos;
    assign m_ar_bits_region = s_ar_bits_region;
    assign m_ar_bits_user   = s_ar_bits_user;
    assign s_r_bits_id      = m_r_bits_id;
    assign s_r_bits_data    = m_r_bits_data;
    assign s_r_bits_resp    = m_r_bits_resp;
    assign s_r_bits_last    = m_r_bits_last;
    assign s_r_bits_user    = m_r_bits_user;

    assign ar_hs     = m_ar_valid && m_ar_ready;
    assign aw_hs     = m_aw_valid && m_aw_ready;
    assign r_hs      = m_r_valid && s_r_ready;
    assign r_last_hs = r_hs && m_r_bits_last;
    assign b_hs      = m_b_valid && s_b_ready;

    txn_counter #(.MAX(MAX_RD)) u_rd_cnt (
        .clk       (Clk),
        .reset     (Reset),
        .inc       (ar_hs),
        .dec       (r_last_hs),
        .count     (rd_cnt),
        .at_max    (rd_at_max),
        .underflow (rd_underflow)
    );

    txn_counter #(.MAX(MAX_WR)) u_wr_cnt (
        .clk       (Clk),
        .reset     (Reset),
        .inc       (aw_hs),
        .dec       (b_hs),
        .count     (wr_cnt),
        .at_max    (wr_at_max),
        .underflow (wr_underflow)
    );

    // Drain FSM: stop new requests, acknowledge once every burst has completed
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            drain_ack_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    drain_ack_q <= 1'b0;
                    if (DrainReq) state <= DRAINING;
                end
                DRAINING: begin
                    if (!DrainReq) begin
                        state <= IDLE;
                    end else if ((rd_cnt == '0) && (wr_cnt == '0)) begin
                        state       <= DRAINED;
                        drain_ack_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!DrainReq) begin
                        state       <= IDLE;
                        drain_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    drain_ack_q <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog: counts cycles with traffic outstanding and no response; sticky flag on expiry
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wd        <= '0;
            timeout_q <= 1'b0;
        end else if (((rd_cnt | wr_cnt) == '0) || r_hs || b_hs) begin
            wd <= '0;
        end else if (wd != WD_W'(TIMEOUT_CYCLES)) begin
            wd <= wd + WD_W'(1);
            if (wd == WD_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
        end
    end

    // Sticky protocol error: a completion arrived with nothing outstanding
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prot_err_q <= 1'b0;
        end else if (rd_underflow || wr_underflow) begin
            prot_err_q <= 1'b1;
        end
    end

    assign DrainAck      = drain_ack_q;
    assign Timeout       = timeout_q;
    assign ProtErr       = prot_err_q;
    assign RdOutstanding = rd_cnt;
    assign WrOutstanding = wr_cnt;

endmodule
